// File: rtl/ldm_stm_sequencer_if.sv
// Memory-side req/ack port of the LDM/STM sequencer.
// The sequencer is the master; the memory system is the slave.
interface ldm_stm_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ARM7 LDM/STM block-transfer sequencer: walks the register list lowest-first,
// one word per req/ack beat, then strobes done and optional base writeback.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          reg_list,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [3:0]           base_idx,
  input  logic                 up,
  input  logic                 pre,
  input  logic                 load,
  input  logic                 wb,
  output logic                 busy,
  output logic                 done,
  ldm_stm_sequencer_if.master  mem,
  output logic [3:0]           rf_rd_idx,
  input  logic [DATA_W-1:0]    rf_rd_data,
  output logic                 rf_we,
  output logic [3:0]           rf_wr_idx,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic                 base_wb_en,
  output logic [ADDR_W-1:0]    base_wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    XFER = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic [15:0]       rem_q, rem_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        base_idx_q, base_idx_d;
  logic              up_q, up_d;
  logic              pre_q, pre_d;
  logic              load_q, load_d;
  logic              wb_q, wb_d;
  logic              empty_q, empty_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] nbase_q, nbase_d;

  logic [4:0]        cnt;
  logic [3:0]        cur_idx;
  logic              cur_found;
  logic [ADDR_W-1:0] offset;
  logic [15:0]       rem_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      list_q     <= '0;
      rem_q      <= '0;
      base_q     <= '0;
      base_idx_q <= '0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      load_q     <= 1'b0;
      wb_q       <= 1'b0;
      empty_q    <= 1'b0;
      addr_q     <= '0;
      nbase_q    <= '0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      rem_q      <= rem_d;
      base_q     <= base_d;
      base_idx_q <= base_idx_d;
      up_q       <= up_d;
      pre_q      <= pre_d;
      load_q     <= load_d;
      wb_q       <= wb_d;
      empty_q    <= empty_d;
      addr_q     <= addr_d;
      nbase_q    <= nbase_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt = cnt + 5'(list_q[i]);
    end
  end

  always_comb begin
    cur_idx   = '0;
    cur_found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (rem_q[i] && !cur_found) begin
        cur_idx   = 4'(i);
        cur_found = 1'b1;
      end
    end
  end

  // An empty list still transfers R15 but moves the base by 16 words.
  assign offset   = empty_q ? ADDR_W'(64) : ADDR_W'({cnt, 2'b00});
  assign rem_next = rem_q & (rem_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    rem_d      = rem_q;
    base_d     = base_q;
    base_idx_d = base_idx_q;
    up_d       = up_q;
    pre_d      = pre_q;
    load_d     = load_q;
    wb_d       = wb_q;
    empty_d    = empty_q;
    addr_d     = addr_q;
    nbase_d    = nbase_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          list_d     = (reg_list == '0) ? 16'h8000 : reg_list;
          rem_d      = (reg_list == '0) ? 16'h8000 : reg_list;
          empty_d    = (reg_list == '0);
          base_d     = base_addr;
          base_idx_d = base_idx;
          up_d       = up;
          pre_d      = pre;
          load_d     = load;
          wb_d       = wb;
          state_d    = CALC;
        end
      end
      CALC: begin
        unique case ({up_q, pre_q})
          2'b10:   addr_d = base_q;
          2'b11:   addr_d = base_q + ADDR_W'(4);
          2'b00:   addr_d = base_q - offset + ADDR_W'(4);
          default: addr_d = base_q - offset;
        endcase
        nbase_d = up_q ? (base_q + offset) : (base_q - offset);
        state_d = XFER;
      end
      XFER: begin
        if (mem.mem_ack) begin
          rem_d  = rem_next;
          addr_d = addr_q + ADDR_W'(4);
          if (rem_next == '0) begin
            state_d = WB;
          end
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == WB);
  assign mem.mem_req   = (state_q == XFER);
  assign mem.mem_we    = (state_q == XFER) & ~load_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = rf_rd_data;
  assign rf_rd_idx     = cur_idx;
  // Suppressed under reset so an abandoned transfer never touches the register file.
  assign rf_we         = (state_q == XFER) & mem.mem_ack & load_q & ~reset;
  assign rf_wr_idx     = cur_idx;
  assign rf_wr_data    = mem.mem_rdata;
  assign base_wb_en    = (state_q == WB) & wb_q & ~(load_q & list_q[base_idx_q]);
  assign base_wb_data  = nbase_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a bench-side model queues the expected
// beats of each block transfer and every acknowledged beat is popped and compared.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [3:0]  base_idx;
  logic        up, pre, load, wb;
  logic        busy, done;
  logic [3:0]  rf_rd_idx;
  logic [31:0] rf_rd_data;
  logic        rf_we;
  logic [3:0]  rf_wr_idx;
  logic [31:0] rf_wr_data;
  logic        base_wb_en;
  logic [31:0] base_wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];

  ldm_stm_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .reg_list     (reg_list),
    .base_addr    (base_addr),
    .base_idx     (base_idx),
    .up           (up),
    .pre          (pre),
    .load         (load),
    .wb           (wb),
    .busy         (busy),
    .done         (done),
    .mem          (mif),
    .rf_rd_idx    (rf_rd_idx),
    .rf_rd_data   (rf_rd_data),
    .rf_we        (rf_we),
    .rf_wr_idx    (rf_wr_idx),
    .rf_wr_data   (rf_wr_data),
    .base_wb_en   (base_wb_en),
    .base_wb_data (base_wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [3:0] i);
    return 32'hC0DE_0000 | {16'h0, i, i, i, i};
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always_comb rf_rd_data = rf_val(rf_rd_idx);
  assign mif.mem_rdata = mem_val(mif.mem_addr);

  task automatic run_op(input logic [15:0] a_list, input logic [31:0] a_base,
                        input logic [3:0] a_idx, input logic a_up, input logic a_pre,
                        input logic a_load, input logic a_wb, input int a_delay,
                        input bit a_spam);
    logic [15:0] eff;
    int          n;
    logic [31:0] off, a, nb;
    logic        exp_en;
    int          wc;
    bit          waiting;
    logic [31:0] p_addr;
    logic        p_we;
    logic [3:0]  p_idx;
    beat_t       b;
    bit          finished;

    eff = (a_list == 16'h0) ? 16'h8000 : a_list;
    n = 0;
    for (int i = 0; i < 16; i++) if (a_list[i]) n++;
    off = (a_list == 16'h0) ? 32'd64 : 32'(4 * n);
    if (a_up && !a_pre)      a = a_base;
    else if (a_up && a_pre)  a = a_base + 32'd4;
    else if (!a_up && !a_pre) a = a_base - off + 32'd4;
    else                     a = a_base - off;
    nb = a_up ? a_base + off : a_base - off;
    exp_en = a_wb & ~(a_load & eff[a_idx]);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (eff[i]) begin
        b.we   = ~a_load;
        b.addr = a;
        b.idx  = 4'(i);
        b.data = a_load ? mem_val(a) : rf_val(4'(i));
        exp_q.push_back(b);
        a = a + 32'd4;
        n++;
      end
    end

    @(negedge clk);
    reg_list = a_list; base_addr = a_base; base_idx = a_idx;
    up = a_up; pre = a_pre; load = a_load; wb = a_wb; start = 1'b1;
    wc = 0; waiting = 0; finished = 0;
    p_addr = '0; p_we = 1'b0; p_idx = '0;

    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (a_spam && cyc == 3) begin start = 1'b1; reg_list = 16'hFFFF; end
      if (a_spam && cyc == 4) reg_list = a_list;
      mif.mem_ack = mif.mem_req && (wc == a_delay);
      #1;
      if (mif.mem_req && waiting) begin
        checks++;
        if (mif.mem_addr !== p_addr || mif.mem_we !== p_we || rf_rd_idx !== p_idx) begin
          errors++;
          $display("FAIL hold_stable: got addr=%h we=%b idx=%0d expected addr=%h we=%b idx=%0d",
                   mif.mem_addr, mif.mem_we, rf_rd_idx, p_addr, p_we, p_idx);
        end
      end
      if (mif.mem_req && mif.mem_ack) begin
        wc = 0; waiting = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got beat at addr=%h expected none", mif.mem_addr);
        end else begin
          b = exp_q.pop_front();
          if (mif.mem_addr !== b.addr || mif.mem_we !== b.we || rf_rd_idx !== b.idx) begin
            errors++;
            $display("FAIL beat_addr: got addr=%h we=%b idx=%0d expected addr=%h we=%b idx=%0d",
                     mif.mem_addr, mif.mem_we, rf_rd_idx, b.addr, b.we, b.idx);
          end
          checks++;
          if (b.we) begin
            if (mif.mem_wdata !== b.data || rf_we !== 1'b0) begin
              errors++;
              $display("FAIL store_data: got wdata=%h rf_we=%b expected wdata=%h rf_we=0",
                       mif.mem_wdata, rf_we, b.data);
            end
          end else begin
            if (rf_we !== 1'b1 || rf_wr_idx !== b.idx || rf_wr_data !== b.data) begin
              errors++;
              $display("FAIL load_write: got rf_we=%b idx=%0d data=%h expected rf_we=1 idx=%0d data=%h",
                       rf_we, rf_wr_idx, rf_wr_data, b.idx, b.data);
            end
          end
        end
      end else begin
        checks++;
        if (rf_we !== 1'b0) begin
          errors++;
          $display("FAIL rf_we_idle: got %b expected 0", rf_we);
        end
        if (mif.mem_req) begin
          wc++; waiting = 1;
          p_addr = mif.mem_addr; p_we = mif.mem_we; p_idx = rf_rd_idx;
        end
      end
      if (done === 1'b1) begin
        finished = 1;
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL beats_left: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (base_wb_en !== exp_en || base_wb_data !== nb) begin
          errors++;
          $display("FAIL writeback: got en=%b data=%h expected en=%b data=%h",
                   base_wb_en, base_wb_data, exp_en, nb);
        end
        checks++;
        if (cyc != n * (a_delay + 1) + 2) begin
          errors++;
          $display("FAIL done_latency: got %0d cycles expected %0d", cyc, n * (a_delay + 1) + 2);
        end
      end
      if (cyc == 400 && !finished) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done expected done within 400 cycles");
      end
    end
    mif.mem_ack = 1'b0;
    exp_q.delete();

    if (a_spam) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL ignored_start: got done=%b busy=%b expected done=0 busy=0", done, busy);
        end
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, mif.mem_req, mif.mem_we, base_wb_en} !== 5'b0 ||
        mif.mem_addr !== 32'h0 || base_wb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b req=%b we=%b addr=%h wben=%b wbdata=%h expected all 0",
               busy, done, mif.mem_req, mif.mem_we, mif.mem_addr, base_wb_en, base_wb_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_stmia;
    run_op(16'h000B, 32'h0000_1000, 4'd13, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_ldmdb_wait;
    run_op(16'h8006, 32'h0000_2010, 4'd13, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0);
  endtask

  task automatic test_ldmia_base_in_list;
    run_op(16'h0016, 32'h0000_5000, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_empty_list;
    run_op(16'h0000, 32'h0000_3000, 4'd13, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    reg_list = 16'h00F0; base_addr = 32'h0000_4000; base_idx = 4'd13;
    up = 1'b1; pre = 1'b0; load = 1'b1; wb = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;            // CALC
    @(negedge clk); mif.mem_ack = 1'b1; #1;  // first beat
    checks++;
    if (rf_we !== 1'b1 || rf_wr_idx !== 4'd4 || mif.mem_addr !== 32'h0000_4000) begin
      errors++;
      $display("FAIL reset_mid_beat1: got rf_we=%b idx=%0d addr=%h expected rf_we=1 idx=4 addr=00004000",
               rf_we, rf_wr_idx, mif.mem_addr);
    end
    @(negedge clk); mif.mem_ack = 1'b0; reset = 1'b1;  // second beat
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mif.mem_req !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: got busy=%b req=%b rf_we=%b done=%b expected all 0",
               busy, mif.mem_req, rf_we, done);
    end
    reset = 1'b0;
    mif.mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || base_wb_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: got rf_we=%b done=%b busy=%b wben=%b expected all 0",
                 rf_we, done, busy, base_wb_en);
      end
    end
    mif.mem_ack = 1'b0;
    run_op(16'h0300, 32'h0000_4100, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_start_while_busy;
    run_op(16'h0111, 32'h0000_6000, 4'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_op(16'h0003, 32'h0000_7000, 4'd13, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h0007, 32'h0000_0004, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0; base_idx = '0;
    up = 1'b0; pre = 1'b0; load = 1'b0; wb = 1'b0; mif.mem_ack = 1'b0;
    test_reset();
    test_stmia();
    test_ldmdb_wait();
    test_ldmia_base_in_list();
    test_empty_list();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
